mips_state_ctrl: RTL and testbench

MIPS_STATE_CTRL -- requirements
Module: mips_state_ctrl

---
 rtl/mips_pkg.sv | 17 +
 rtl/mips_state_ctrl.sv | 87 ++++++++
 tb/tb_mips_state_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS sequencing definitions: the 3-bit state encoding used by the
// controller, the instruction register and the datapath.
package mips_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXEC      = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } state_t;

  localparam int RETIRE_W = 32;

endpackage

// File: rtl/mips_state_ctrl.sv
// Multi-cycle MIPS sequencer: FSM plus retired-instruction counter.
// Optional HALT_ON_ZERO_PC_EN: a completion to next PC 0 parks the CPU in HALT.
module mips_state_ctrl
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                waitrequest,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                writes_reg,
  input  logic                alu_busy,
  input  logic                next_pc_zero,
  output logic [2:0]          state,
  output logic                mem_read,
  output logic                mem_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                active,
  output logic [RETIRE_W-1:0] retired
);

  state_t              r_state;
  logic                r_is_load;
  logic [RETIRE_W-1:0] r_retired;
  logic                w_done;
  state_t              w_done_state;

`ifdef HALT_ON_ZERO_PC_EN
  assign w_done_state = next_pc_zero ? HALT : FETCH_REQ;
  assign active       = (r_state != HALT);
`else
  logic w_unused_next_pc_zero;
  assign w_unused_next_pc_zero = next_pc_zero;
  assign w_done_state          = FETCH_REQ;
  assign active                = 1'b1;
`endif

  // Completion is the cycle in which the instruction leaves its final state.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      EXEC:      w_done = !alu_busy && !is_load && !is_store && !writes_reg;
      MEM:       w_done = !waitrequest && !r_is_load;
      WRITEBACK: w_done = 1'b1;
      default:   w_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH_REQ;
      r_is_load <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        FETCH_REQ: if (!waitrequest) r_state <= FETCH;
        FETCH:     r_state <= DECODE;
        DECODE:    r_state <= EXEC;
        EXEC: begin
          if (!alu_busy) begin
            // A load+store encoding is treated as a load from here on.
            r_is_load <= is_load;
            if (is_load || is_store) r_state <= MEM;
            else if (writes_reg)     r_state <= WRITEBACK;
            else                     r_state <= w_done_state;
          end
        end
        MEM: begin
          if (!waitrequest) r_state <= r_is_load ? WRITEBACK : w_done_state;
        end
        WRITEBACK: r_state <= w_done_state;
        HALT:      r_state <= HALT;
        default:   r_state <= FETCH_REQ;
      endcase
      if (w_done) r_retired <= r_retired + 1'b1;
    end
  end

  assign state     = r_state;
  assign mem_read  = (r_state == FETCH_REQ) || ((r_state == MEM) && r_is_load);
  assign mem_write = (r_state == MEM) && !r_is_load;
  assign reg_write = (r_state == WRITEBACK);
  assign pc_write  = w_done;
  assign retired   = r_retired;

endmodule

// File: tb/tb_mips_state_ctrl.sv
// Directed bench for mips_state_ctrl; inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_mips_state_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        writes_reg = 1'b0;
  logic        alu_busy = 1'b0;
  logic        next_pc_zero = 1'b0;
  logic [2:0]  state;
  logic        mem_read;
  logic        mem_write;
  logic        pc_write;
  logic        reg_write;
  logic        active;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  mips_state_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .waitrequest  (waitrequest),
    .is_load      (is_load),
    .is_store     (is_store),
    .writes_reg   (writes_reg),
    .alu_busy     (alu_busy),
    .next_pc_zero (next_pc_zero),
    .state        (state),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .active       (active),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobes packed as {mem_read, mem_write, pc_write, reg_write}
  function automatic logic [31:0] strb();
    return {28'd0, mem_read, mem_write, pc_write, reg_write};
  endfunction

  task automatic run_front(input string tag);
    step(); chk({tag, "_fetch"},  {29'd0, state}, 32'd1);
    step(); chk({tag, "_decode"}, {29'd0, state}, 32'd2);
    step(); chk({tag, "_exec"},   {29'd0, state}, 32'd3);
  endtask

  initial begin
    // reset state
    step();
    chk("rst_state",   {29'd0, state}, 32'd0);
    chk("rst_strobes", strb(), 32'b1000);
    chk("rst_active",  {31'd0, active}, 32'd1);
    chk("rst_retired", retired, 32'd0);
    reset = 1'b0;

    // ALU op: 0,1,2,3,5,0
    writes_reg = 1'b1;
    run_front("alu");
    chk("alu_exec_strobes", strb(), 32'b0000);
    step();
    chk("alu_wb_state",   {29'd0, state}, 32'd5);
    chk("alu_wb_strobes", strb(), 32'b0011);
    step();
    chk("alu_done_state", {29'd0, state}, 32'd0);
    chk("alu_retired",    retired, 32'd1);

    // load with 3 wait cycles in MEM
    writes_reg = 1'b0;
    is_load    = 1'b1;
    run_front("ld");
    step();
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_hold_state",   {29'd0, state}, 32'd4);
      chk("ld_mem_hold_strobes", strb(), 32'b1000);
      step();
    end
    waitrequest = 1'b0;
    chk("ld_mem_last_state",   {29'd0, state}, 32'd4);
    chk("ld_mem_last_strobes", strb(), 32'b1000);
    step();
    chk("ld_wb_state",   {29'd0, state}, 32'd5);
    chk("ld_wb_strobes", strb(), 32'b0011);
    step();
    chk("ld_done_state", {29'd0, state}, 32'd0);
    chk("ld_retired",    retired, 32'd2);

    // MULT: EXEC held for 33 cycles
    is_load    = 1'b0;
    writes_reg = 1'b1;
    run_front("mul");
    alu_busy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("mul_busy_state",   {29'd0, state}, 32'd3);
      chk("mul_busy_strobes", strb(), 32'b0000);
    end
    alu_busy = 1'b0;
    step();
    chk("mul_wb_state", {29'd0, state}, 32'd5);
    step();
    chk("mul_done_state", {29'd0, state}, 32'd0);
    chk("mul_retired",    retired, 32'd3);

    // store: completes out of MEM
    writes_reg = 1'b0;
    is_store   = 1'b1;
    run_front("st");
    step();
    chk("st_mem_state",   {29'd0, state}, 32'd4);
    chk("st_mem_strobes", strb(), 32'b0110);
    step();
    chk("st_done_state", {29'd0, state}, 32'd0);
    chk("st_retired",    retired, 32'd4);

    // load+store behaves as load
    is_load = 1'b1;
    run_front("ldst");
    step();
    chk("ldst_mem_strobes", strb(), 32'b1000);
    step();
    chk("ldst_wb_state", {29'd0, state}, 32'd5);
    step();
    chk("ldst_retired", retired, 32'd5);

    // reset in the middle of a store MEM phase
    is_load = 1'b0;
    run_front("rstm");
    step();
    chk("rstm_mem_write", {31'd0, mem_write}, 32'd1);
    waitrequest = 1'b1;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    chk("rstm_state",     {29'd0, state}, 32'd0);
    chk("rstm_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rstm_retired",   retired, 32'd0);
    step();
    chk("fetch_req_hold_state", {29'd0, state}, 32'd0);
    chk("fetch_req_hold_rd",    {31'd0, mem_read}, 32'd1);
    waitrequest = 1'b0;
    is_store    = 1'b0;

    // counter wrap via preload at all-ones
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    chk("wrap_preload", retired, 32'hFFFF_FFFF);
    run_front("wrap");
    chk("wrap_exec_pc_write", {31'd0, pc_write}, 32'd1);
    step();
    chk("wrap_state",   {29'd0, state}, 32'd0);
    chk("wrap_retired", retired, 32'd0);

    // jump to PC 0
    next_pc_zero = 1'b1;
    run_front("jz");
    step();
`ifdef HALT_ON_ZERO_PC_EN
    chk("jz_halt_state",   {29'd0, state}, 32'd6);
    chk("jz_halt_active",  {31'd0, active}, 32'd0);
    chk("jz_halt_strobes", strb(), 32'b0000);
    for (int i = 0; i < 50; i++) begin
      step();
      chk("jz_halt_hold", {29'd0, state}, 32'd6);
    end
    chk("jz_halt_retired", retired, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("jz_rst_state",   {29'd0, state}, 32'd0);
    chk("jz_rst_active",  {31'd0, active}, 32'd1);
    chk("jz_rst_retired", retired, 32'd0);
`else
    chk("jz_state",   {29'd0, state}, 32'd0);
    chk("jz_active",  {31'd0, active}, 32'd1);
    chk("jz_retired", retired, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
